lieat_ifu_pcctrl: RTL and testbench

- Fetch-PC sequencer and static branch predictor for the IFU.
- Issues one instruction-fetch request at a time and drives the returned word through the IFU predecoder.
- Picks the next PC from the predecode result: jal/bxx/jalr targets, ecall/mret vectors, fence.i handshake.
- Hands each instruction with its PC and prediction to the IDU. EXU flush redirects it at any time.

---
 rtl/lieat_ifu_pcctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_lieat_ifu_pcctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lieat_ifu_pcctrl.sv
// ============================================================================
// lieat_ifu_pcctrl
//   Fetch-PC sequencer with a static branch predictor for the IFU. Keeps a
//   single fetch outstanding, buffers the returned word for the external
//   predecoder, chooses the next fetch PC from the predecode flags, and hands
//   each instruction (with its PC and prediction) to the IDU. An EXU flush
//   redirects fetch from any state.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   ifu_req_*                    fetch request channel (valid/ready/pc)
//   ifu_rsp_*                    fetch response channel (valid/ready/inst)
//   dec_inst                     buffered word presented to the predecoder
//   dec_rs1/imm/jal/jalr/bxx/
//   dec_ecall/mret/fencei        predecode results for dec_inst
//   jalr_rs1_idx/rdata/busy      register-file read port for jalr targets
//   csr_mtvec, csr_mepc          trap vector and trap return PC
//   exu_flush, exu_flush_pc      redirect from the execution unit
//   fencei_req, fencei_ack       icache invalidate handshake
//   ifu_o_*                      instruction hand-off to the IDU
// ============================================================================
module lieat_ifu_pcctrl #(
    parameter int              XLEN       = 32,
    parameter int              RGIDX_SIZE = 5,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,

    output logic                  ifu_req_valid,
    input  logic                  ifu_req_ready,
    output logic [XLEN-1:0]       ifu_req_pc,

    input  logic                  ifu_rsp_valid,
    output logic                  ifu_rsp_ready,
    input  logic [XLEN-1:0]       ifu_rsp_inst,

    output logic [XLEN-1:0]       dec_inst,
    input  logic [RGIDX_SIZE-1:0] dec_rs1,
    input  logic [XLEN-1:0]       dec_imm,
    input  logic                  dec_jal,
    input  logic                  dec_jalr,
    input  logic                  dec_bxx,
    input  logic                  dec_ecall,
    input  logic                  dec_mret,
    input  logic                  dec_fencei,

    output logic [RGIDX_SIZE-1:0] jalr_rs1_idx,
    input  logic [XLEN-1:0]       jalr_rs1_rdata,
    input  logic                  jalr_rs1_busy,

    input  logic [XLEN-1:0]       csr_mtvec,
    input  logic [XLEN-1:0]       csr_mepc,

    input  logic                  exu_flush,
    input  logic [XLEN-1:0]       exu_flush_pc,

    output logic                  fencei_req,
    input  logic                  fencei_ack,

    output logic                  ifu_o_valid,
    input  logic                  ifu_o_ready,
    output logic [XLEN-1:0]       ifu_o_inst,
    output logic [XLEN-1:0]       ifu_o_pc,
    output logic                  ifu_o_pred_taken
);

    typedef enum logic [2:0] {
        S_REQ,      // request pc_r from memory
        S_WAIT,     // one fetch outstanding
        S_HOLD,     // buffered word offered to IDU, next PC predicted
        S_JALR,     // waiting for rs1 to become readable
        S_FENCEI,   // waiting for icache invalidate
        S_DROP      // outstanding response belongs to a flushed path
    } state_t;

    state_t                  state_q, state_d;
    logic [XLEN-1:0]         pc_r, pc_d;
    logic [XLEN-1:0]         ibuf_q, ibuf_d;
    logic [RGIDX_SIZE-1:0]   rs1_q, rs1_d;
    logic [XLEN-1:0]         imm_q, imm_d;
    logic                    flush_pend_q, flush_pend_d;

    logic [XLEN-1:0]         pc_plus4;
    logic [XLEN-1:0]         pc_plus_imm;
    logic [XLEN-1:0]         hold_next_pc;
    logic [XLEN-1:0]         jalr_sum;
    logic                    bxx_taken;
    logic                    hold;

    assign pc_plus4    = pc_r + XLEN'(4);
    assign pc_plus_imm = pc_r + dec_imm;
    assign jalr_sum    = jalr_rs1_rdata + imm_q;

    // Static prediction: backward branches (negative offset) are loops.
    assign bxx_taken   = dec_bxx & dec_imm[XLEN-1];

    // NOTE: every signal written in an always_comb gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        hold_next_pc = pc_plus4;
        if (dec_jal)                   hold_next_pc = pc_plus_imm;
        else if (dec_bxx)              hold_next_pc = bxx_taken ? pc_plus_imm : pc_plus4;
        else if (dec_ecall)            hold_next_pc = csr_mtvec;
        else if (dec_mret)             hold_next_pc = csr_mepc;
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_r;
        ibuf_d        = ibuf_q;
        rs1_d         = rs1_q;
        imm_d         = imm_q;
        flush_pend_d  = flush_pend_q;
        ifu_req_valid = 1'b0;
        ifu_rsp_ready = 1'b0;
        fencei_req    = 1'b0;
        hold          = 1'b0;

        case (state_q)
            S_REQ: begin
                // Never issue a fetch for a PC that is being redirected.
                ifu_req_valid = ~exu_flush;
                if (ifu_req_valid && ifu_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                ifu_rsp_ready = 1'b1;
                if (ifu_rsp_valid) begin
                    ibuf_d  = ifu_rsp_inst;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                hold = 1'b1;
                if (ifu_o_ready) begin
                    if (dec_jalr) begin
                        // Predecode outputs follow ibuf; capture what the
                        // target computation needs before ibuf is reused.
                        rs1_d   = dec_rs1;
                        imm_d   = dec_imm;
                        state_d = S_JALR;
                    end else if (dec_fencei) begin
                        state_d = S_FENCEI;
                    end else begin
                        pc_d    = hold_next_pc;
                        state_d = S_REQ;
                    end
                end
            end
            S_JALR: begin
                if (!jalr_rs1_busy) begin
                    pc_d    = {jalr_sum[XLEN-1:1], 1'b0};
                    state_d = S_REQ;
                end
            end
            S_FENCEI: begin
                fencei_req = 1'b1;
                if (fencei_ack) begin
                    // A flush during the invalidate already set pc_r to the
                    // redirect target; otherwise resume after the fence.i.
                    pc_d         = flush_pend_q ? pc_r : pc_plus4;
                    flush_pend_d = 1'b0;
                    state_d      = S_REQ;
                end
            end
            S_DROP: begin
                ifu_rsp_ready = 1'b1;
                if (ifu_rsp_valid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase

        // Flush overrides whatever the state logic decided above.
        if (exu_flush) begin
            pc_d = exu_flush_pc;
            case (state_q)
                S_WAIT:   state_d = ifu_rsp_valid ? S_REQ : S_DROP;
                S_DROP:   state_d = ifu_rsp_valid ? S_REQ : S_DROP;
                S_FENCEI: begin
                    // The icache invalidate cannot be cancelled: keep
                    // waiting for its ack, then fetch from the new PC.
                    state_d      = S_FENCEI;
                    flush_pend_d = 1'b1;
                end
                default:  state_d = S_REQ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_r         <= RESET_PC;
            ibuf_q       <= '0;
            rs1_q        <= '0;
            imm_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_r         <= pc_d;
            ibuf_q       <= ibuf_d;
            rs1_q        <= rs1_d;
            imm_q        <= imm_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign ifu_req_pc       = pc_r;
    assign dec_inst         = ibuf_q;
    assign jalr_rs1_idx     = rs1_q;

    // IDU outputs are qualified by S_HOLD so they read as zero when idle.
    assign ifu_o_valid      = hold;
    assign ifu_o_inst       = hold ? ibuf_q : '0;
    assign ifu_o_pc         = hold ? pc_r   : '0;
    assign ifu_o_pred_taken = hold & (dec_jal | dec_jalr | dec_ecall | dec_mret | bxx_taken);

endmodule

// File: tb/tb_lieat_ifu_pcctrl.sv
// ============================================================================
// tb_lieat_ifu_pcctrl
//   Bench for lieat_ifu_pcctrl. Plays memory, predecoder, register file,
//   icache and IDU. The expected fetch stream comes from an ISA-level model:
//   each accepted instruction's successor PC is derived from its RV32
//   encoding and the static prediction rule, or from the flush target.
// ============================================================================
module tb_lieat_ifu_pcctrl;

    localparam logic [31:0] RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] ECALL     = 32'h0000_0073;
    localparam logic [31:0] MRET      = 32'h3020_0073;
    localparam logic [31:0] FENCEI    = 32'h0000_100F;

    typedef enum {F_NONE, F_WAIT, F_WAIT_RSP, F_HOLD, F_JALR, F_FENCEI} flush_e;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_req_pc;
    logic        ifu_rsp_valid, ifu_rsp_ready;
    logic [31:0] ifu_rsp_inst;
    logic [31:0] dec_inst;
    logic [4:0]  dec_rs1;
    logic [31:0] dec_imm;
    logic        dec_jal, dec_jalr, dec_bxx, dec_ecall, dec_mret, dec_fencei;
    logic [4:0]  jalr_rs1_idx;
    logic [31:0] jalr_rs1_rdata;
    logic        jalr_rs1_busy;
    logic [31:0] csr_mtvec, csr_mepc;
    logic        exu_flush;
    logic [31:0] exu_flush_pc;
    logic        fencei_req, fencei_ack;
    logic        ifu_o_valid, ifu_o_ready;
    logic [31:0] ifu_o_inst, ifu_o_pc;
    logic        ifu_o_pred_taken;

    logic [31:0] regs [32];
    logic [31:0] exp_pc;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    lieat_ifu_pcctrl dut (
        .clk              (clk),
        .rst              (rst),
        .ifu_req_valid    (ifu_req_valid),
        .ifu_req_ready    (ifu_req_ready),
        .ifu_req_pc       (ifu_req_pc),
        .ifu_rsp_valid    (ifu_rsp_valid),
        .ifu_rsp_ready    (ifu_rsp_ready),
        .ifu_rsp_inst     (ifu_rsp_inst),
        .dec_inst         (dec_inst),
        .dec_rs1          (dec_rs1),
        .dec_imm          (dec_imm),
        .dec_jal          (dec_jal),
        .dec_jalr         (dec_jalr),
        .dec_bxx          (dec_bxx),
        .dec_ecall        (dec_ecall),
        .dec_mret         (dec_mret),
        .dec_fencei       (dec_fencei),
        .jalr_rs1_idx     (jalr_rs1_idx),
        .jalr_rs1_rdata   (jalr_rs1_rdata),
        .jalr_rs1_busy    (jalr_rs1_busy),
        .csr_mtvec        (csr_mtvec),
        .csr_mepc         (csr_mepc),
        .exu_flush        (exu_flush),
        .exu_flush_pc     (exu_flush_pc),
        .fencei_req       (fencei_req),
        .fencei_ack       (fencei_ack),
        .ifu_o_valid      (ifu_o_valid),
        .ifu_o_ready      (ifu_o_ready),
        .ifu_o_inst       (ifu_o_inst),
        .ifu_o_pc         (ifu_o_pc),
        .ifu_o_pred_taken (ifu_o_pred_taken)
    );

    // ---------------- RV32 immediate helpers ----------------
    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction
    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction
    function automatic logic [31:0] imm_i(input logic [31:0] i);
        return {{20{i[31]}}, i[31:20]};
    endfunction
    function automatic logic [31:0] enc_jal(input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'h6F};
    endfunction
    function automatic logic [31:0] enc_bxx(input logic [31:0] imm, input logic [4:0] rs1,
                                            input logic [4:0] rs2);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_jalr(input logic [31:0] imm, input logic [4:0] rs1,
                                             input logic [4:0] rd);
        return {imm[11:0], rs1, 3'b000, rd, 7'h67};
    endfunction

    // ---------------- predecoder and register file stand-ins ----------------
    always_comb begin
        dec_jal    = (dec_inst[6:0] == 7'h6F);
        dec_jalr   = (dec_inst[6:0] == 7'h67);
        dec_bxx    = (dec_inst[6:0] == 7'h63);
        dec_ecall  = (dec_inst == ECALL);
        dec_mret   = (dec_inst == MRET);
        dec_fencei = (dec_inst[6:0] == 7'h0F) && (dec_inst[14:12] == 3'b001);
        dec_rs1    = dec_inst[19:15];
        dec_imm    = dec_jal ? imm_j(dec_inst) : dec_bxx ? imm_b(dec_inst) : imm_i(dec_inst);
    end

    assign jalr_rs1_rdata = regs[jalr_rs1_idx];

    // ---------------- architectural reference model ----------------
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] inst);
        logic [31:0] off;
        if (inst[6:0] == 7'h6F) return pc + imm_j(inst);
        if (inst[6:0] == 7'h63) begin
            off = imm_b(inst);
            return ($signed(off) < 0) ? pc + off : pc + 32'd4;
        end
        if (inst[6:0] == 7'h67) return (regs[inst[19:15]] + imm_i(inst)) & 32'hFFFF_FFFE;
        if (inst == ECALL)      return csr_mtvec;
        if (inst == MRET)       return csr_mepc;
        return pc + 32'd4;
    endfunction

    function automatic logic model_pred(input logic [31:0] inst);
        logic [31:0] off;
        off = imm_b(inst);
        return (inst[6:0] == 7'h6F) || (inst[6:0] == 7'h67) || (inst == ECALL) ||
               (inst == MRET) || ((inst[6:0] == 7'h63) && off[31]);
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Redirect while sitting in S_REQ; the request must be suppressed.
    task automatic redirect(input logic [31:0] tgt);
        @(negedge clk);
        ifu_req_ready = 1'b1;
        exu_flush     = 1'b1;
        exu_flush_pc  = tgt;
        #1 check("flush_blocks_req", ifu_req_valid, 1'b0);
        @(negedge clk);
        exu_flush     = 1'b0;
        ifu_req_ready = 1'b0;
        exp_pc        = tgt;
    endtask

    // One instruction through fetch, hold and any follow-up handshake,
    // optionally with a flush injected at the stage named by fm.
    task automatic run_inst(input logic [31:0] inst, input flush_e fm,
                            input logic [31:0] ftgt, input int busy_n);
        bit          got;
        int          n;
        logic [31:0] nxt;

        csr_mtvec = $urandom;
        csr_mepc  = $urandom;

        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ifu_req_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (ifu_req_valid && ifu_req_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("req_timeout", 32'd0, 32'd1);
            return;
        end
        check("req_pc", ifu_req_pc, exp_pc);
        check("idle_o_valid", ifu_o_valid, 1'b0);

        @(negedge clk);
        ifu_req_ready = 1'b0;
        #1;
        check("wait_rsp_ready", ifu_rsp_ready, 1'b1);
        check("wait_no_req", ifu_req_valid, 1'b0);

        if (fm == F_WAIT) begin
            exu_flush    = 1'b1;
            exu_flush_pc = ftgt;
            @(negedge clk);
            exu_flush = 1'b0;
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                #1 check("drop_o_valid", ifu_o_valid, 1'b0);
                @(negedge clk);
            end
            ifu_rsp_valid = 1'b1;
            ifu_rsp_inst  = inst;
            #1 check("drop_rsp_ready", ifu_rsp_ready, 1'b1);
            @(negedge clk);
            ifu_rsp_valid = 1'b0;
            #1;
            check("drop_o_valid_after", ifu_o_valid, 1'b0);
            check("drop_then_req", ifu_req_valid, 1'b1);
            exp_pc = ftgt;
            return;
        end

        repeat ($urandom_range(0, 3)) @(negedge clk);
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = inst;

        if (fm == F_WAIT_RSP) begin
            exu_flush    = 1'b1;
            exu_flush_pc = ftgt;
            @(negedge clk);
            exu_flush     = 1'b0;
            ifu_rsp_valid = 1'b0;
            #1;
            check("wr_o_valid", ifu_o_valid, 1'b0);
            check("wr_then_req", ifu_req_valid, 1'b1);
            exp_pc = ftgt;
            return;
        end

        @(negedge clk);
        ifu_rsp_valid = 1'b0;
        ifu_rsp_inst  = $urandom;
        #1;
        check("o_valid", ifu_o_valid, 1'b1);
        check("o_pc", ifu_o_pc, exp_pc);
        check("o_inst", ifu_o_inst, inst);
        check("pred_taken", ifu_o_pred_taken, model_pred(inst));
        check("hold_no_req", ifu_req_valid, 1'b0);
        nxt = model_next(exp_pc, inst);

        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            #1 check("hold_stall_valid", ifu_o_valid, 1'b1);
        end

        ifu_o_ready = 1'b1;
        if (fm == F_HOLD) begin
            exu_flush    = 1'b1;
            exu_flush_pc = ftgt;
            @(negedge clk);
            exu_flush   = 1'b0;
            ifu_o_ready = 1'b0;
            #1 check("hf_o_valid", ifu_o_valid, 1'b0);
            exp_pc = ftgt;
            return;
        end
        @(negedge clk);
        ifu_o_ready = 1'b0;

        if (inst[6:0] == 7'h67) begin
            #1 check("jalr_idx", jalr_rs1_idx, inst[19:15]);
            for (int k = 0; k < busy_n; k++) begin
                jalr_rs1_busy = 1'b1;
                if (fm == F_JALR && k == busy_n - 1) begin
                    exu_flush    = 1'b1;
                    exu_flush_pc = ftgt;
                end
                #1 check("jalr_stall_no_req", ifu_req_valid, 1'b0);
                @(negedge clk);
                exu_flush = 1'b0;
            end
            jalr_rs1_busy = 1'b0;
            if (fm == F_JALR) begin
                exp_pc = ftgt;
                return;
            end
            @(negedge clk);
            exp_pc = nxt;
        end else if (inst == FENCEI) begin
            #1 check("fencei_req_on", fencei_req, 1'b1);
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                if (fm == F_FENCEI && k == n / 2) begin
                    exu_flush    = 1'b1;
                    exu_flush_pc = ftgt;
                end
                #1;
                check("fencei_hold", fencei_req, 1'b1);
                check("fencei_no_req", ifu_req_valid, 1'b0);
                @(negedge clk);
                exu_flush = 1'b0;
            end
            fencei_ack = 1'b1;
            #1 check("fencei_ack_cycle", fencei_req, 1'b1);
            @(negedge clk);
            fencei_ack = 1'b0;
            #1 check("fencei_req_off", fencei_req, 1'b0);
            exp_pc = (fm == F_FENCEI) ? ftgt : nxt;
        end else begin
            exp_pc = nxt;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r, inst, tgt;
        flush_e      fm;
        int          kind, p;

        rst           = 1'b1;
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_inst  = '0;
        jalr_rs1_busy = 1'b0;
        csr_mtvec     = 32'h8000_0080;
        csr_mepc      = 32'h8000_0300;
        exu_flush     = 1'b0;
        exu_flush_pc  = '0;
        fencei_ack    = 1'b0;
        ifu_o_ready   = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_o_valid", ifu_o_valid, 1'b0);
        check("rst_fencei_req", fencei_req, 1'b0);
        check("rst_pred", ifu_o_pred_taken, 1'b0);
        check("rst_o_inst", ifu_o_inst, 32'd0);
        check("rst_o_pc", ifu_o_pc, 32'd0);
        check("rst_req_valid", ifu_req_valid, 1'b1);
        check("rst_req_pc", ifu_req_pc, RESET_PC);
        exp_pc = RESET_PC;

        // Directed scenarios.
        run_inst(NOP, F_NONE, '0, 0);
        run_inst(NOP, F_NONE, '0, 0);
        redirect(32'h8000_0000);
        run_inst(enc_jal(32'd16), F_NONE, '0, 0);
        run_inst(NOP, F_NONE, '0, 0);
        redirect(32'h8000_0020);
        run_inst(enc_bxx(32'hFFFF_FFF8, 5'd1, 5'd2), F_NONE, '0, 0);
        run_inst(NOP, F_NONE, '0, 0);
        redirect(32'h8000_0020);
        run_inst(enc_bxx(32'd8, 5'd1, 5'd2), F_NONE, '0, 0);
        run_inst(NOP, F_NONE, '0, 0);
        regs[5] = 32'h8000_1003;
        run_inst(enc_jalr(32'd0, 5'd5, 5'd1), F_NONE, '0, 3);
        run_inst(NOP, F_NONE, '0, 0);
        run_inst(NOP, F_WAIT, 32'h8000_0400, 0);
        run_inst(NOP, F_NONE, '0, 0);
        redirect(32'h8000_0100);
        run_inst(FENCEI, F_FENCEI, 32'h8000_0200, 0);
        run_inst(NOP, F_NONE, '0, 0);
        run_inst(ECALL, F_NONE, '0, 0);
        run_inst(MRET, F_NONE, '0, 0);
        redirect(32'hFFFF_FFFC);
        run_inst(NOP, F_NONE, '0, 0);
        run_inst(NOP, F_NONE, '0, 0);

        // Randomized instruction stream with randomized flush placement.
        for (int it = 0; it < 250; it++) begin
            r    = $urandom;
            kind = $urandom_range(0, 7);
            case (kind)
                0, 1:    inst = {r[31:7], 7'h13};
                2:       inst = enc_jal(r);
                3:       inst = enc_bxx(r, r[19:15], r[24:20]);
                4:       inst = enc_jalr(r, r[19:15], r[11:7]);
                5:       inst = ECALL;
                6:       inst = MRET;
                default: inst = FENCEI;
            endcase
            tgt = $urandom;
            p   = $urandom_range(0, 9);
            fm  = F_NONE;
            if (p == 0)      fm = F_WAIT;
            else if (p == 1) fm = F_WAIT_RSP;
            else if (p == 2) fm = F_HOLD;
            else if (p == 3) fm = (kind == 4) ? F_JALR : (kind == 7) ? F_FENCEI : F_NONE;
            else if (p == 4) redirect($urandom);
            run_inst(inst, fm, tgt, $urandom_range(1, 3));
        end
        run_inst(NOP, F_NONE, '0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
